tt_um_out_buffer: RTL and testbench
===================================

// Module: tt_um_out_buffer
// PURPOSE
//  Downstream of the ternary mat-vec multiplier. Captures one signed result per row (rows 0..OUT_LEN-1).
//  Requantizes each result with a rounding arithmetic right shift and optional ReLU.
//  Stores the results in a ping-pong pair of banks. Streams each completed frame out over a valid/ready port.
//  Lets the multiplier run free: the next frame fills one bank while the previous frame drains from the other.
// PARAMETERS
//  OUT_LEN   7  rows per frame (output vector length); max 7, so row code 7 is never a row
//  BIT_WIDTH 8  result width in bits, two's complement
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          reset, synchronous, active-low
//  in_valid   in   1          in_row/in_data carry a multiplier result this cycle
//  in_row     in   3          row index of in_data; codes >= OUT_LEN are ignored
//  in_data    in   BIT_WIDTH  signed row result
//  cfg_shift  in   3          right-shift amount, 0..7
//  cfg_relu   in   1          1: clamp negative results to 0
//  out_ready  in   1          consumer accepts out_data this cycle
//  out_valid  out  1          out_data/out_row/out_last are valid
//  out_data   out  BIT_WIDTH  requantized result
//  out_row    out  3          row index of out_data
//  out_last   out  1          out_row == OUT_LEN-1
//  drop_cnt   out  8          frames discarded because no bank was free; saturates at 255
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): all outputs 0; both banks empty; wr_bank=0, rd_bank=0; row mask cleared.
//  Reset mid-frame or mid-stream discards all buffered data. No partial frame is emitted after reset.
//  Write side: a write is in_valid && in_row < OUT_LEN.
//  A row-0 write starts a frame. It clears the row mask and samples cfg_shift/cfg_relu into frame-config regs.
//  A row-0 write checks whether bank wr_bank is full. If it is full, the whole frame is dropped:
//    drop_cnt increments once and all writes are ignored until the next row-0 write.
//  A bank freed by the read side in the same cycle counts as empty for this check (free has priority).
//  Writes to rows 1..OUT_LEN-1 before any row-0 write after reset are ignored.
//  Each write stores requant(in_data) at bank[wr_bank][in_row] and sets mask bit in_row.
//  Rewriting a row overwrites it and does not duplicate it.
//  Frame complete: the mask becomes all-ones (normally on row OUT_LEN-1).
//    Next cycle: the bank is marked full and wr_bank toggles.
//  A row-0 write in the same cycle as completion belongs to the next frame and goes to the toggled bank.
//  requant(x): y = (x + (s ? 1<<(s-1) : 0)) >>> s, with s = frame cfg_shift and a BIT_WIDTH+1 intermediate.
//    If relu && y < 0 then y = 0. The result is always representable in BIT_WIDTH bits, so there is no saturation.
//    Example: s=2: 7 -> 2, -7 -> -2, -128 -> -32.
//  Read side: when bank rd_bank is full, out_valid=1, out_row=rd_ptr, out_data=bank[rd_bank][rd_ptr].
//  out_* are held stable while out_valid && !out_ready.
//  A handshake is out_valid && out_ready. On a handshake rd_ptr increments.
//    On a handshake with out_last: rd_ptr=0, the bank is freed, rd_bank toggles,
//    and out_valid deasserts next cycle unless the other bank is already full (back-to-back, no bubble).
//  Latency: the write completing a frame -> out_valid high 2 cycles later (1 mark-full + 1 registered output).
//  Sustained throughput: one frame per OUT_LEN+1 clocks at the producer (row code 7 idle slot),
//    one element per clock at the consumer.
//  Both banks full: the producer's next frame is dropped as above. The buffered frames are never corrupted.
// STRUCTURE
//  Package tt_out_pkg: OUT_LEN/BIT_WIDTH defaults, ROW_W=3, and the requant function (shared with the model).
//  Sub-module tt_um_requant: combinational shift/round/ReLU, instantiated once on the write path.
//  Storage: 2 x OUT_LEN x BIT_WIDTH flops (no SRAM). Bank state: full[1:0], wr_bank, rd_bank,
//  mask[OUT_LEN-1:0], drop flag, rd_ptr.
// TESTING
//  1. Rows 0..6 with data 10,-10,3,-3,127,-128,0; shift=0, relu=0; out_ready=1
//     -> 7 beats, same values, out_last on row 6, out_valid starts 2 cycles after the row-6 write.
//  2. shift=2, relu=1; data 7,-7,6,5,-1,1,-128 -> 2,0,2,1,0,0,0.
//  3. out_ready=0 during 3 frames -> frames 1 and 2 are buffered, frame 3 is dropped (drop_cnt=1).
//     Release -> 14 beats in order frame1, frame2, with no bubble between them.
//  4. out_ready toggling 1,0,1,0 -> out_data stable while stalled; no beat lost or duplicated.
//  5. Reset asserted after row 3 of a frame, and separately mid-stream
//     -> out_valid=0 and drop_cnt=0 next cycle; stale data never appears.
//  6. Row order 0,1,2,1,3..6 with the second row-1 write = 55; also in_row=7 with in_valid=1
//     -> row 1 reads 55; row code 7 is ignored; exactly 7 beats.

Source files
------------

// File: rtl/tt_out_pkg.sv
// Shared constants and the requantization function for the output buffer.
// The function is also used as the reference by anything modelling it.
package tt_out_pkg;

    localparam int OUT_LEN   = 7;
    localparam int BIT_WIDTH = 8;
    localparam int ROW_W     = 3;

    // Rounding arithmetic right shift with one guard bit, then optional ReLU.
    function automatic logic [BIT_WIDTH-1:0] requant(
        input logic [BIT_WIDTH-1:0] x,
        input logic [2:0]           s,
        input logic                 relu
    );
        logic signed [BIT_WIDTH:0] ext;
        logic signed [BIT_WIDTH:0] rnd;
        logic signed [BIT_WIDTH:0] sh;
        ext = {x[BIT_WIDTH-1], x};
        rnd = '0;
        if (s != 3'd0)
            rnd = (BIT_WIDTH+1)'(1) << (s - 3'd1);
        sh = (ext + rnd) >>> s;
        requant = sh[BIT_WIDTH-1:0];
        if (relu && sh[BIT_WIDTH])
            requant = '0;
    endfunction

endpackage

// File: rtl/tt_um_requant.sv
// Combinational requantizer on the buffer write path.
// Shift, round-half-up and optional ReLU of one row result.
module tt_um_requant
    import tt_out_pkg::*;
(
    input  logic [BIT_WIDTH-1:0] data,
    input  logic [2:0]           shift,
    input  logic                 relu,
    output logic [BIT_WIDTH-1:0] result
);

    assign result = requant(data, shift, relu);

endmodule

// File: rtl/tt_um_out_buffer.sv
// Ping-pong output buffer behind the ternary mat-vec multiplier.
// One bank fills from the multiplier while the other drains over valid/ready.
module tt_um_out_buffer
    import tt_out_pkg::*;
#(
    parameter int OUT_LEN   = tt_out_pkg::OUT_LEN,
    parameter int BIT_WIDTH = tt_out_pkg::BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ROW_W-1:0]     in_row,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic [2:0]           cfg_shift,
    input  logic                 cfg_relu,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [ROW_W-1:0]     out_row,
    output logic                 out_last,
    output logic [7:0]           drop_cnt
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_LEN - 1);

    logic [BIT_WIDTH-1:0] mem [2][OUT_LEN];
    logic [1:0]           full;
    logic                 wr_bank;
    logic                 rd_bank;
    logic                 done;
    logic                 idle;
    logic [OUT_LEN-1:0]   mask;
    logic [OUT_LEN-1:0]   mask_nx;
    logic [ROW_W-1:0]     rd_ptr;
    logic [ROW_W-1:0]     ld_ptr;
    logic [2:0]           shift_q;
    logic                 relu_q;

    logic                 wr;
    logic                 row0;
    logic                 wb;
    logic                 wb_full;
    logic                 wen;
    logic                 complete;
    logic                 hs_last;
    logic                 hold;
    logic                 ld;
    logic                 ld_bank;
    logic [2:0]           rq_shift;
    logic                 rq_relu;
    logic [BIT_WIDTH-1:0] rq;

    tt_um_requant u_requant (
        .data   (in_data),
        .shift  (rq_shift),
        .relu   (rq_relu),
        .result (rq)
    );

    // A frame closing this cycle has already handed its bank over.
    always_comb begin
        wr       = in_valid && (in_row <= LAST_ROW);
        row0     = wr && (in_row == '0);
        hs_last  = out_valid && out_ready && out_last;
        wb       = done ? ~wr_bank : wr_bank;
        wb_full  = full[wb] && !(hs_last && (rd_bank == wb));
        wen      = row0 ? !wb_full : (wr && !idle);
        mask_nx  = row0 ? '0 : mask;
        if (wen)
            mask_nx[in_row] = 1'b1;
        complete = wen && (&mask_nx);
        rq_shift = row0 ? cfg_shift : shift_q;
        rq_relu  = row0 ? cfg_relu : relu_q;
    end

    always_comb begin
        hold    = out_valid && !out_ready;
        ld_bank = rd_bank;
        ld_ptr  = rd_ptr;
        ld      = 1'b0;
        if (!out_valid) begin
            ld = full[rd_bank];
        end else if (out_last) begin
            ld_bank = ~rd_bank;
            ld_ptr  = '0;
            ld      = full[~rd_bank];
        end else begin
            ld_ptr = rd_ptr + 1'b1;
            ld     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wen)
            mem[wb][in_row] <= rq;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            done      <= 1'b0;
            idle      <= 1'b1;
            mask      <= '0;
            rd_ptr    <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            drop_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= complete;
            if (done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (hs_last)
                full[rd_bank] <= 1'b0;
            if (row0) begin
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
                mask    <= '0;
                idle    <= wb_full;
                if (wb_full && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
            if (wen) begin
                mask <= complete ? '0 : mask_nx;
                if (complete)
                    idle <= 1'b1;
            end
            if (!hold) begin
                rd_bank   <= ld_bank;
                rd_ptr    <= ld_ptr;
                out_valid <= ld;
                out_row   <= ld ? ld_ptr : '0;
                out_data  <= ld ? mem[ld_bank][ld_ptr] : '0;
                out_last  <= ld && (ld_ptr == LAST_ROW);
            end
        end
    end

endmodule

// File: tb/tb_tt_um_out_buffer.sv
// Directed bench for the ping-pong output buffer.
// Expected beats are hand-computed per vector.
module tb_tt_um_out_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_row;
    logic [7:0] in_data;
    logic [2:0] cfg_shift;
    logic       cfg_relu;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_row;
    logic       out_last;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_data[$];
    int q_row[$];
    int q_last[$];
    int q_cyc[$];

    int d1[7], d2[7], e2[7], d2b[7], e2b[7], d2c[7], e2c[7];
    int da[7], db[7], dc[7], d4[7], d5[7], e6[7];

    always #5 clk = ~clk;

    tt_um_out_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_data   (in_data),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(int'($signed(out_data)));
            q_row.push_back(int'(out_row));
            q_last.push_back(int'(out_last));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_row.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic wr(input int row, input int data);
        in_valid = 1'b1;
        in_row   = 3'(row);
        in_data  = 8'(data);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_rows(input int d[7]);
        for (int i = 0; i < 7; i++)
            wr(i, d[i]);
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 200 && q_data.size() < n; i++)
            tick();
        check({tag, " count"}, q_data.size(), n);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++)
            tick();
        check({tag, " valid"}, int'(out_valid), 1);
    endtask

    task automatic check_frame(input string tag, input int base, input int e[7]);
        for (int i = 0; i < 7; i++) begin
            if (q_data.size() > base + i) begin
                check($sformatf("%s data%0d", tag, i), q_data[base+i], e[i]);
                check($sformatf("%s row%0d", tag, i), q_row[base+i], i);
                check($sformatf("%s last%0d", tag, i), q_last[base+i], int'(i == 6));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        d1  = '{10, -10, 3, -3, 127, -128, 0};
        d2  = '{7, -7, 6, 5, -1, 1, -128};
        e2  = '{2, 0, 2, 1, 0, 0, 0};
        d2b = '{7, -7, -128, 127, -2, 2, -3};
        e2b = '{2, -2, -32, 32, 0, 1, -1};
        d2c = '{127, -128, 63, 64, -64, -65, 0};
        e2c = '{1, -1, 0, 1, 0, -1, 0};
        da  = '{1, 2, 3, 4, 5, 6, 7};
        db  = '{-1, -2, -3, -4, -5, -6, -7};
        dc  = '{100, 101, 102, 103, 104, 105, 106};
        d4  = '{20, -20, 64, -64, 1, -1, 99};
        d5  = '{11, 12, 13, 14, 15, 16, 17};
        e6  = '{1, 55, 3, 4, 5, 6, 7};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        in_data   = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst valid", int'(out_valid), 0);
        check("rst data", int'(out_data), 0);
        check("rst row", int'(out_row), 0);
        check("rst last", int'(out_last), 0);
        check("rst drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        tick();

        // passthrough and latency
        out_ready = 1'b1;
        clear_q();
        send_rows(d1);
        check("t1 lat0", int'(out_valid), 0);
        tick();
        check("t1 lat1", int'(out_valid), 0);
        tick();
        check("t1 lat2", int'(out_valid), 1);
        check("t1 first", int'($signed(out_data)), 10);
        wait_beats("t1", 7);
        check_frame("t1", 0, d1);

        // config sampled on row 0 only
        clear_q();
        cfg_shift = 3'd2;
        cfg_relu  = 1'b1;
        wr(0, d2[0]);
        cfg_shift = 3'd0;
        cfg_relu  = 1'b0;
        for (int i = 1; i < 7; i++)
            wr(i, d2[i]);
        wait_beats("t2", 7);
        check_frame("t2", 0, e2);

        clear_q();
        cfg_shift = 3'd2;
        send_rows(d2b);
        wait_beats("t2b", 7);
        check_frame("t2b", 0, e2b);

        clear_q();
        cfg_shift = 3'd7;
        send_rows(d2c);
        wait_beats("t2c", 7);
        check_frame("t2c", 0, e2c);
        cfg_shift = 3'd0;

        // both banks full, third frame dropped
        out_ready = 1'b0;
        clear_q();
        send_rows(da);
        send_rows(db);
        send_rows(dc);
        repeat (3) tick();
        check("t3 drop", int'(drop_cnt), 1);
        check("t3 held valid", int'(out_valid), 1);
        check("t3 held row", int'(out_row), 0);
        check("t3 held data", int'($signed(out_data)), 1);
        out_ready = 1'b1;
        wait_beats("t3", 14);
        check_frame("t3a", 0, da);
        check_frame("t3b", 7, db);
        if (q_cyc.size() >= 8)
            check("t3 bubble", q_cyc[7] - q_cyc[6], 1);
        repeat (10) tick();
        check("t3 no extra", q_data.size(), 14);

        // toggling ready
        out_ready = 1'b0;
        clear_q();
        send_rows(d4);
        wait_valid("t4");
        for (int k = 0; k < 40 && q_data.size() < 7; k++) begin
            int   sd;
            int   sr;
            logic sv;
            out_ready = 1'b0;
            sv = out_valid;
            sd = int'($signed(out_data));
            sr = int'(out_row);
            tick();
            if (sv) begin
                check("t4 stall valid", int'(out_valid), 1);
                check("t4 stall data", int'($signed(out_data)), sd);
                check("t4 stall row", int'(out_row), sr);
            end
            out_ready = 1'b1;
            tick();
        end
        wait_beats("t4", 7);
        check_frame("t4", 0, d4);
        repeat (4) tick();
        check("t4 no dup", q_data.size(), 7);

        // reset mid-frame: stale rows must not surface
        out_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++)
            wr(i, 50 + i);
        rst_n = 1'b0;
        tick();
        check("t5a valid", int'(out_valid), 0);
        check("t5a drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        for (int i = 4; i < 7; i++)
            wr(i, 60 + i);
        repeat (6) tick();
        check("t5a idle valid", int'(out_valid), 0);
        check("t5a no beats", q_data.size(), 0);

        // reset mid-stream
        out_ready = 1'b0;
        send_rows(d5);
        wait_valid("t5b");
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("t5b valid", int'(out_valid), 0);
        check("t5b data", int'(out_data), 0);
        check("t5b drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        clear_q();
        repeat (10) tick();
        check("t5b no beats", q_data.size(), 0);
        check("t5b idle valid", int'(out_valid), 0);

        // rewrite and out-of-range row code
        clear_q();
        wr(0, 1);
        wr(1, 2);
        wr(2, 3);
        wr(7, 99);
        wr(1, 55);
        wr(3, 4);
        wr(7, -5);
        wr(4, 5);
        wr(5, 6);
        wr(6, 7);
        wait_beats("t6", 7);
        check_frame("t6", 0, e6);
        repeat (10) tick();
        check("t6 exact", q_data.size(), 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
